matrix_tile_loader: RTL

// - Streaming successor to the combinational matrix_fill unpacker. Accepts IN_W-bit beats over a

---
 rtl/matrix_pkg.sv | 30 +++
 rtl/tile_bank.sv | 63 ++++++
 rtl/matrix_tile_loader.sv | 108 ++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared helpers for the matrix tile loader: derived widths and the
// stream-element to tile-slot mapping used when filling a bank.
package matrix_pkg;

  function automatic int tile_w(input int elem_w, input int rows, input int cols);
    return rows * cols * elem_w;
  endfunction

  function automatic int elems_per_beat(input int in_w, input int elem_w);
    return in_w / elem_w;
  endfunction

  function automatic int beats_per_tile(input int t_w, input int in_w);
    return t_w / in_w;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Row-major slot r*COLS+c collapses to k itself; column-major walks rows first.
  function automatic int elem_slot(input int k, input logic transpose,
                                   input int rows, input int cols);
    if (transpose) begin
      return (k % rows) * cols + (k / rows);
    end
    return k;
  endfunction

endpackage

// File: rtl/tile_bank.sv
// One ping-pong bank: tile storage plus its full and transpose flags.
module tile_bank
  import matrix_pkg::*;
#(
  parameter int ELEM_W = 4,
  parameter int ROWS   = 2,
  parameter int COLS   = 4,
  parameter int IN_W   = 16,
  parameter int TILE_W = tile_w(ELEM_W, ROWS, COLS),
  parameter int EPB    = elems_per_beat(IN_W, ELEM_W),
  parameter int CNT_W  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [CNT_W-1:0]  i_beat,
  input  logic [IN_W-1:0]   i_data,
  input  logic              i_transpose,
  input  logic              i_set_full,
  input  logic              i_clear_full,
  output logic [TILE_W-1:0] o_data,
  output logic              o_full,
  output logic              o_transposed
);

  localparam int NELEM = ROWS * COLS;

  logic [TILE_W-1:0] r_data;
  logic              r_full;
  logic              r_transposed;
  logic              w_tr;

  // Beat 0 uses the live flag; later beats reuse the one latched on beat 0.
  assign w_tr = (i_beat == '0) ? i_transpose : r_transposed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data       <= '0;
      r_full       <= 1'b0;
      r_transposed <= 1'b0;
    end else begin
      if (i_we) begin
        for (int j = 0; j < EPB; j++) begin
          r_data[(NELEM - 1 - elem_slot(int'(i_beat) * EPB + j, w_tr, ROWS, COLS)) * ELEM_W +: ELEM_W]
            <= i_data[IN_W - 1 - j * ELEM_W -: ELEM_W];
        end
        if (i_beat == '0) begin
          r_transposed <= i_transpose;
        end
      end
      if (i_set_full) begin
        r_full <= 1'b1;
      end else if (i_clear_full) begin
        r_full <= 1'b0;
      end
    end
  end

  assign o_data       = r_data;
  assign o_full       = r_full;
  assign o_transposed = r_transposed;

endmodule

// File: rtl/matrix_tile_loader.sv
// Streams IN_W-bit beats into ROWS x COLS tiles held in two ping-pong banks
// and hands each completed tile on as one flat word.
module matrix_tile_loader
  import matrix_pkg::*;
#(
  parameter int ELEM_W  = 4,
  parameter int ROWS    = 2,
  parameter int COLS    = 4,
  parameter int IN_W    = 16,
  localparam int TILE_W = tile_w(ELEM_W, ROWS, COLS),
  localparam int EPB    = elems_per_beat(IN_W, ELEM_W),
  localparam int BEATS  = beats_per_tile(TILE_W, IN_W),
  localparam int CNT_W  = cnt_w(BEATS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_last,
  input  logic              in_transpose,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TILE_W-1:0] out_data,
  output logic              out_transposed,
  output logic [1:0]        tiles_buffered,
  output logic              err_framing
);

  if (IN_W % ELEM_W != 0) begin : g_bad_in_w
    $fatal(1, "IN_W must be a multiple of ELEM_W");
  end
  if (TILE_W % IN_W != 0) begin : g_bad_tile_w
    $fatal(1, "IN_W must divide ROWS*COLS*ELEM_W");
  end

  logic [CNT_W-1:0]  r_beat_cnt;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic              r_err_framing;
  logic [1:0]        w_full;
  logic [1:0]        w_tr;
  logic [TILE_W-1:0] w_data [2];
  logic              w_accept;
  logic              w_drain;
  logic              w_last_beat;

  assign w_last_beat = (r_beat_cnt == CNT_W'(BEATS - 1));
  assign in_ready    = rst_n & ~w_full[r_wr_bank];
  assign w_accept    = in_valid & in_ready;
  assign out_valid   = w_full[r_rd_bank];
  assign w_drain     = out_valid & out_ready;

  for (genvar g = 0; g < 2; g++) begin : g_bank
    tile_bank #(
      .ELEM_W (ELEM_W),
      .ROWS   (ROWS),
      .COLS   (COLS),
      .IN_W   (IN_W),
      .TILE_W (TILE_W),
      .EPB    (EPB),
      .CNT_W  (CNT_W)
    ) u_bank (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_we         (w_accept && (r_wr_bank == 1'(g))),
      .i_beat       (r_beat_cnt),
      .i_data       (in_data),
      .i_transpose  (in_transpose),
      .i_set_full   (w_accept && w_last_beat && (r_wr_bank == 1'(g))),
      .i_clear_full (w_drain && (r_rd_bank == 1'(g))),
      .o_data       (w_data[g]),
      .o_full       (w_full[g]),
      .o_transposed (w_tr[g])
    );
  end

  assign out_data       = w_data[r_rd_bank];
  assign out_transposed = w_tr[r_rd_bank];
  assign tiles_buffered = {1'b0, w_full[0]} + {1'b0, w_full[1]};
  assign err_framing    = r_err_framing;

  // Framing is judged against beat_cnt; in_last never steers the fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt    <= '0;
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b0;
      r_err_framing <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_last_beat) begin
          r_beat_cnt <= '0;
          r_wr_bank  <= ~r_wr_bank;
        end else begin
          r_beat_cnt <= r_beat_cnt + 1'b1;
        end
        if (in_last != w_last_beat) begin
          r_err_framing <= 1'b1;
        end
      end
      if (w_drain) begin
        r_rd_bank <= ~r_rd_bank;
      end
    end
  end

endmodule
